// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding and
// default timing constants, also used by push-button counter benches.
package button_pkg;

    // Debounce/hold FSM states; encoding is fixed so benches can decode it.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_e;

    // Default number of stable synchronised samples needed to accept a change.
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Default number of held cycles, counted from press acceptance, before a long press.
    localparam int LONG_CYCLES_DEF = 64;

endpackage : button_pkg

// File: rtl/button_sync.sv
// Two-flop synchroniser for a single asynchronous board input, with a
// synchronous active-low reset that clears both stages.
module button_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Shift the raw level through two flops so downstream logic only sees a settled value.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so both stages
        // sample the pre-edge values and the chain really is two flops deep.
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : button_sync

// File: rtl/button_debounce_pulse.sv
// Push-button conditioning: synchronise, debounce, and emit registered
// single-cycle press / release / long-press pulses plus a debounced level.
module button_debounce_pulse
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

    logic              btn_s;
    btn_state_e        state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              long_fired_q;
    logic              long_hit;
    logic              pressed_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;

    button_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (button),
        .q_o (btn_s)
    );

    // Saturating hold-counter increment and detection of the one step that reaches the long threshold.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_hit   = 1'b0;
        if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if ((hold_cnt_q == HOLD_PRE) && !long_fired_q) begin
            long_hit = 1'b1;
        end
    end

    // Debounce/hold FSM with all outputs registered; every decision uses the synchronised level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            pressed_q    <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            // Pulses fall back to 0 unless a branch below raises them for this one cycle.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q  <= DB_PRESS;
                        db_cnt_q <= '0;
                    end
                end

                DB_PRESS: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q      <= HELD;
                        press_q      <= 1'b1;
                        pressed_q    <= 1'b1;
                        hold_cnt_q   <= '0;
                        long_fired_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end

                HELD: begin
                    if (!btn_s) begin
                        state_q  <= DB_RELEASE;
                        db_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                        if (long_hit) begin
                            long_q       <= 1'b1;
                            long_fired_q <= 1'b1;
                        end
                    end
                end

                DB_RELEASE: begin
                    if (!btn_s || (db_cnt_q != DB_LAST)) begin
                        // Release not yet accepted: the hold time keeps running.
                        hold_cnt_q <= hold_cnt_d;
                        if (long_hit) begin
                            long_q       <= 1'b1;
                            long_fired_q <= 1'b1;
                        end
                    end
                    if (btn_s) begin
                        // Release rejected; hold progress and long-fired flag survive.
                        state_q <= HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        pressed_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule : button_debounce_pulse

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Conditioning front end that sits between a raw mechanical push button and the press counter / LED logic.
- Synchronises the asynchronous button input and rejects contact bounce.
- Emits clean single-cycle press, release and long-press event pulses, plus a debounced level.
- Downstream counters clock-enable on press_pulse instead of using the raw button as a clock.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a level change; legal range 2..65535.
- LONG_CYCLES, 64: cycles in the held state, counted from press acceptance, before long_pulse fires; legal range 2..65535.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- button  in  1  raw asynchronous push-button level, 1 = pressed
- pressed  out  1  debounced button level
- press_pulse  out  1  one-cycle pulse on an accepted press
- release_pulse  out  1  one-cycle pulse on an accepted release
- long_pulse  out  1  one-cycle pulse, at most once per press

Behaviour:
- Reset:
  - One clock; rst is synchronous and active-low.
  - rst=0 at a rising edge clears both synchroniser flops, the debounce counter, the hold counter and all outputs to 0, and forces state IDLE.
  - Reset overrides all other activity, including mid-debounce and mid-hold.
- Synchroniser: two flops, button -> s1 -> btn_s. All FSM decisions use btn_s only.
- Debounce counter: width clog2(DEBOUNCE_CYCLES). Hold counter: width clog2(LONG_CYCLES). Both are unsigned.
- FSM states (encoded in the shared package):
  - IDLE: btn_s=1 -> DB_PRESS, db_cnt<=0. Otherwise stay.
  - DB_PRESS:
    - btn_s=0 -> IDLE (bounce rejected, no pulse).
    - btn_s=1 and db_cnt==DEBOUNCE_CYCLES-1 -> HELD, press_pulse<=1, pressed<=1, hold_cnt<=0.
    - Otherwise db_cnt++.
  - HELD:
    - btn_s=0 -> DB_RELEASE, db_cnt<=0.
    - Otherwise hold_cnt increments, saturating at LONG_CYCLES-1.
    - long_pulse<=1 on the cycle hold_cnt transitions to LONG_CYCLES-1, once only.
  - DB_RELEASE:
    - btn_s=1 -> HELD (release rejected). hold_cnt and the long-fired flag are kept, so no second press_pulse or long_pulse is produced.
    - btn_s=0 and db_cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse<=1, pressed<=0.
    - Otherwise db_cnt++. hold_cnt keeps counting in this state.
- Latency:
  - Button first sampled high at edge 0 and held stable: press_pulse is high for exactly the one cycle after edge DEBOUNCE_CYCLES+2.
  - Release latency is symmetric.
- Pulses are registered and last exactly one cycle. press_pulse and release_pulse are never high in the same cycle.
- long_pulse fires only if the hold counter saturates before the release is accepted.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no output change in either direction.
- Button held through reset deassertion: treated as a fresh press, so press_pulse follows DEBOUNCE_CYCLES+2 edges after the first non-reset edge.
- No combinational path from button to any output.

Decomposition:
- Shared package (button_pkg): FSM state localparams (IDLE=2'd0, DB_PRESS=2'd1, HELD=2'd2, DB_RELEASE=2'd3) and default DEBOUNCE_CYCLES/LONG_CYCLES constants, reused by push-button counter benches.
- One sub-module: button_sync, a 2-flop synchroniser with synchronous active-low reset, reusable for other board inputs.

Test Plan (DEBOUNCE_CYCLES=16, LONG_CYCLES=64):
- Reset: rst=0 for 3 cycles with button=1 -> all outputs 0 throughout. After rst=1, press_pulse at edge 18, pressed=1 from the same cycle.
- Clean press/release: button 0->1 held 40 cycles, then 0 -> one press_pulse 18 edges after rise, one release_pulse 18 edges after fall, long_pulse never.
- Bounce: button toggles every 3 cycles for 30 cycles, then stays 1 -> no pulses during bounce. Exactly one press_pulse 18 edges after the final rise.
- Long press: button=1 for 200 cycles -> press_pulse at edge 18, long_pulse exactly once 63 edges later, pressed=1 until the release is accepted.
- Release glitch: while HELD, button=0 for 5 cycles then 1 -> no release_pulse, no second press_pulse, pressed stays 1.
- Reset mid-operation: rst=0 while in DB_PRESS with db_cnt=10 -> next cycle state IDLE and all outputs 0. No pulse emitted for the aborted press.
